// File: rtl/dmux8way16_buf_pkg.sv
// rtl/dmux8way16_buf_pkg.sv - shared geometry and helpers for the buffered 8-way demux
package dmux8way16_buf_pkg;

  localparam int N_CH   = 8;
  localparam int DATA_W = 16;
  localparam int SEL_W  = 3;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [N_CH-1:0]   chmask_t;

  // Channels written by an accepted offer: all of them on broadcast, else one-hot sel.
  function automatic chmask_t dest_mask(input logic [SEL_W-1:0] sel, input logic bcast);
    chmask_t m;
    if (bcast) m = '1;
    else       m = chmask_t'(1) << sel;
    return m;
  endfunction

endpackage

// File: rtl/dmux_slot.sv
// rtl/dmux_slot.sv - one output channel: data register plus full flag
module dmux_slot
  import dmux8way16_buf_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  word_t in_data,
  input  logic  out_ready,
  output logic  full,
  output logic  space,
  output word_t data
);

  logic  full_q, full_d;
  word_t data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    // A load wins over a pop so a same-cycle pop+load keeps the slot full.
    if (load) begin
      data_d = in_data;
      full_d = 1'b1;
    end else if (full_q && out_ready) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full  = full_q;
  assign space = ~full_q | out_ready;
  assign data  = data_q;

endmodule

// File: rtl/dmux8way16_buf.sv
// rtl/dmux8way16_buf.sv - buffered 16-bit 1-to-8 demux with broadcast and accept counter
module dmux8way16_buf
  import dmux8way16_buf_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       in,
  input  logic [2:0]        sel,
  input  logic              bcast,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [15:0]       out_a,
  output logic [15:0]       out_b,
  output logic [15:0]       out_c,
  output logic [15:0]       out_d,
  output logic [15:0]       out_e,
  output logic [15:0]       out_f,
  output logic [15:0]       out_g,
  output logic [15:0]       out_h,
  output logic [7:0]        out_valid,
  input  logic [7:0]        out_ready,
  output logic [CNT_W-1:0]  xfer_cnt
);

  chmask_t    full, space, load;
  word_t      data [N_CH];
  logic       accept;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_slot
      dmux_slot u_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (load[gi]),
        .in_data   (in),
        .out_ready (out_ready[gi]),
        .full      (full[gi]),
        .space     (space[gi]),
        .data      (data[gi])
      );
    end
  endgenerate

  // Broadcast needs room in every channel; unicast only in the selected one.
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      if (bcast) in_ready = &space;
      else       in_ready = space[sel];
    end
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    load = '0;
    if (accept) load = dest_mask(sel, bcast);
  end

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (accept) xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) xfer_cnt_q <= '0;
    else       xfer_cnt_q <= xfer_cnt_d;
  end

  assign xfer_cnt  = xfer_cnt_q;
  assign out_valid = full;
  assign out_a = data[0];
  assign out_b = data[1];
  assign out_c = data[2];
  assign out_d = data[3];
  assign out_e = data[4];
  assign out_f = data[5];
  assign out_g = data[6];
  assign out_h = data[7];

endmodule

// File: tb/tb_dmux8way16_buf.sv
// tb/tb_dmux8way16_buf.sv - scoreboard bench for dmux8way16_buf
module tb_dmux8way16_buf;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in = '0;
  logic [2:0]  sel = '0;
  logic        bcast = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_a, out_b, out_c, out_d, out_e, out_f, out_g, out_h;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready = '0;
  logic [3:0]  xfer_cnt;

  logic [15:0] outs [8];
  assign outs[0] = out_a;
  assign outs[1] = out_b;
  assign outs[2] = out_c;
  assign outs[3] = out_d;
  assign outs[4] = out_e;
  assign outs[5] = out_f;
  assign outs[6] = out_g;
  assign outs[7] = out_h;

  dmux8way16_buf #(.CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .sel       (sel),
    .bcast     (bcast),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .out_e     (out_e),
    .out_f     (out_f),
    .out_g     (out_g),
    .out_h     (out_h),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [15:0] sb [8][$];
  logic [7:0]  mdl_full = '0;
  logic [3:0]  mdl_cnt = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check in_ready, score pops/accepts, check state after edge.
  task automatic cycle(input logic rst, input logic [15:0] d, input logic [2:0] s,
                       input logic b, input logic v, input logic [7:0] r);
    logic exp_rdy;
    logic [15:0] w;
    @(negedge clk);
    reset = rst; in = d; sel = s; bcast = b; in_valid = v; out_ready = r;
    #1;
    exp_rdy = 1'b0;
    if (!rst) begin
      if (b) exp_rdy = &(~mdl_full | r);
      else   exp_rdy = ~mdl_full[s] | r[s];
    end
    check("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    if (rst) begin
      for (int i = 0; i < 8; i++) sb[i].delete();
      mdl_full = '0;
      mdl_cnt = '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (mdl_full[i] && r[i]) begin
          w = sb[i].pop_front();
          check("pop_data", {16'b0, outs[i]}, {16'b0, w});
          mdl_full[i] = 1'b0;
        end
      end
      if (v && exp_rdy) begin
        for (int i = 0; i < 8; i++) begin
          if (b || s == 3'(i)) begin
            sb[i].push_back(d);
            mdl_full[i] = 1'b1;
          end
        end
        mdl_cnt = mdl_cnt + 4'd1;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", {24'b0, out_valid}, {24'b0, mdl_full});
    check("xfer_cnt", {28'b0, xfer_cnt}, {28'b0, mdl_cnt});
    for (int i = 0; i < 8; i++)
      if (mdl_full[i]) check("held_data", {16'b0, outs[i]}, {16'b0, sb[i][0]});
  endtask

  initial begin
    // reset with a concurrent offer: nothing may be accepted
    cycle(1'b1, 16'hFFFF, 3'd2, 1'b0, 1'b1, 8'hFF);
    cycle(1'b1, 16'hFFFF, 3'd2, 1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) check("reset_out", {16'b0, outs[i]}, 32'h0);

    cycle(1'b0, 16'h1234, 3'd3, 1'b0, 1'b1, 8'h00);
    check("uni_valid", {24'b0, out_valid}, 32'h08);
    check("uni_out_d", {16'b0, out_d}, 32'h1234);
    check("uni_cnt", {28'b0, xfer_cnt}, 32'h1);

    cycle(1'b0, 16'h5555, 3'd3, 1'b0, 1'b1, 8'h00);
    check("blocked_out_d", {16'b0, out_d}, 32'h1234);
    check("blocked_cnt", {28'b0, xfer_cnt}, 32'h1);

    cycle(1'b0, 16'hBEEF, 3'd3, 1'b0, 1'b1, 8'h08);
    check("thru_valid3", {31'b0, out_valid[3]}, 32'h1);
    check("thru_out_d", {16'b0, out_d}, 32'hBEEF);

    cycle(1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, 8'hFF);
    cycle(1'b0, 16'hA5A5, 3'd5, 1'b1, 1'b1, 8'h00);
    check("bc_valid", {24'b0, out_valid}, 32'hFF);
    for (int i = 0; i < 8; i++) check("bc_out", {16'b0, outs[i]}, 32'hA5A5);

    cycle(1'b0, 16'h1111, 3'd0, 1'b1, 1'b1, 8'h00);
    cycle(1'b0, 16'h2222, 3'd0, 1'b1, 1'b1, 8'hFE);
    cycle(1'b0, 16'h5A5A, 3'd0, 1'b1, 1'b1, 8'hFF);
    // sel/bcast wobble while stalled
    cycle(1'b0, 16'h3333, 3'd1, 1'b0, 1'b1, 8'h00);
    cycle(1'b0, 16'h4444, 3'd6, 1'b1, 1'b1, 8'h00);
    cycle(1'b0, 16'h6666, 3'd6, 1'b0, 1'b1, 8'h40);

    for (int k = 0; k < 200; k++)
      cycle(1'b0, 16'($urandom), 3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0), 8'($urandom));

    // counter wrap with a 4-bit counter
    cycle(1'b1, 16'h0, 3'd0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 17; k++)
      cycle(1'b0, 16'(k + 16'h100), 3'(k), 1'b0, 1'b1, 8'hFF);
    check("wrap_cnt", {28'b0, xfer_cnt}, 32'h1);

    cycle(1'b0, 16'hC0DE, 3'd0, 1'b1, 1'b1, 8'hFF);
    cycle(1'b1, 16'hDEAD, 3'd4, 1'b0, 1'b1, 8'h00);
    check("rst_valid", {24'b0, out_valid}, 32'h0);
    check("rst_cnt", {28'b0, xfer_cnt}, 32'h0);
    for (int i = 0; i < 8; i++) check("rst_out", {16'b0, outs[i]}, 32'h0);
    cycle(1'b0, 16'h0, 3'd0, 1'b0, 1'b0, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmux8way16_buf.md
DMUX8WAY16_BUF -- requirements
Module: dmux8way16_buf

Interface
REQ-001 SHALL have parameter: CNT_W, default 16, width of accepted-word counter.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in  input  16  word to distribute.
REQ-005 SHALL have port: sel  input  3  destination channel 0..7 (a..h); ignored when bcast=1.
REQ-006 SHALL have port: bcast  input  1  1 = write word to all 8 channels.
REQ-007 SHALL have port: in_valid  input  1  producer offers in/sel/bcast.
REQ-008 SHALL have port: in_ready  output  1  block accepts this cycle.
REQ-009 SHALL have ports: out_a..out_h  output  16 each  channel data registers.
REQ-010 SHALL have port: out_valid  output  8  bit i = channel i holds a word.
REQ-011 SHALL have port: out_ready  input  8  bit i = consumer i takes word.
REQ-012 SHALL have port: xfer_cnt  output  CNT_W  accepted input words, wrapping.

Function
REQ-013 SHALL keep per-channel full flag F[i]; out_valid[i] = F[i] (registered).
REQ-014 SHALL define pop[i] = F[i] & out_ready[i]; out_ready[i] with F[i]=0 has no effect.
REQ-015 SHALL drive in_ready, when bcast=0, as ~F[sel] | out_ready[sel] (combinational).
REQ-016 SHALL drive in_ready, when bcast=1, as AND over i of (~F[i] | out_ready[i]).
REQ-017 SHALL define accept = in_valid & in_ready; in_ready is valid regardless of in_valid.
REQ-018 SHALL, on unicast accept, load channel sel with in and set F[sel] at the next edge (latency 1 cycle).
REQ-019 SHALL, on broadcast accept, load all 8 channels with in and set all F at the next edge.
REQ-020 SHALL, on pop[i] without a load into i, clear F[i] at the next edge.
REQ-021 SHALL, on simultaneous pop[i] and load into i, keep F[i]=1 and hold the new word (full throughput, 1 word/cycle/channel).
REQ-022 SHALL hold out_x stable while out_valid[x]=1 and no pop/load occurs on x.
REQ-023 SHALL leave non-selected channels unchanged except for their own pops.
REQ-024 SHALL increment xfer_cnt by exactly 1 per accept (broadcast counts 1), wrapping 2^CNT_W-1 -> 0.
REQ-025 SHALL make no state change when in_valid=0 except pops.
REQ-026 SHALL tolerate sel/bcast changing while in_valid=1 and in_ready=0 (no protocol error; in_ready re-evaluated each cycle).

Reset
REQ-027 SHALL, while reset=1 at a clock edge, set F=0, out_a..out_h=0, xfer_cnt=0.
REQ-028 SHALL force in_ready=0 while reset=1; reset dominates any concurrent accept or pop.
REQ-029 SHALL, when reset is asserted mid-operation, discard all held words (no partial delivery after reset).

Structure
REQ-030 SHALL place in a shared package: channel count 8, data width 16, sel width 3.
REQ-031 SHALL implement one sub-module dmux_slot (one 16-bit register + full flag + load/pop logic), instantiated 8 times.
REQ-032 SHALL keep in_ready the only combinational input-to-output path.

Verification
REQ-033 SHALL test: reset, then in=16'h1234, sel=3, in_valid=1 one cycle -> next cycle out_valid=8'b0000_1000, out_d=16'h1234, xfer_cnt=1.
REQ-034 SHALL test: channel 3 full, out_ready=0, offer sel=3 -> in_ready=0, out_d stays 16'h1234, xfer_cnt unchanged.
REQ-035 SHALL test: channel 3 full, out_ready[3]=1, offer 16'hBEEF sel=3 -> in_ready=1; next cycle out_valid[3]=1, out_d=16'hBEEF.
REQ-036 SHALL test: all empty, bcast=1, in=16'hA5A5 -> next cycle out_valid=8'hFF, all outputs 16'hA5A5; then with channel 0 full and out_ready=0, bcast -> in_ready=0.
REQ-037 SHALL test: CNT_W=4, 17 accepts -> xfer_cnt=1; reset asserted while channels full and in_valid=1 -> next cycle out_valid=0, outputs 0, xfer_cnt=0.
